// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type and small operation-classification helpers.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } mdu_state_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
   endfunction

   function automatic logic op_is_rem(input mdu_op_e op);
      return op inside {MDU_REM, MDU_REMU};
   endfunction

   function automatic logic op_signed_a(input mdu_op_e op);
      return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic op_signed_b(input mdu_op_e op);
      return op inside {MDU_MULH, MDU_DIV, MDU_REM};
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle on a shared {hi,lo}
// accumulator, operating on magnitudes with sign fix-up on the last step.
module muldiv_unit
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic [2:0]      mdu_control,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] mdu_result,
   output logic            zero
);

   localparam int CW = $clog2(XLEN);

   mdu_state_e      state_q, state_d;
   mdu_op_e         op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] result_q, result_d;

   mdu_op_e           acc_op;
   logic              neg_a, neg_b, div_zero, div_ovf;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_sub;
   logic [XLEN-1:0]   hi_n, lo_n;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

   always_comb begin
      acc_op   = mdu_op_e'(mdu_control);
      neg_a    = op_signed_a(acc_op) & operand_a[XLEN-1];
      neg_b    = op_signed_b(acc_op) & operand_b[XLEN-1];
      a_abs    = neg_a ? -operand_a : operand_a;
      b_abs    = neg_b ? -operand_b : operand_b;
      div_zero = op_is_div(acc_op) && (operand_b == '0);
      div_ovf  = (acc_op == MDU_DIV || acc_op == MDU_REM) &&
                 (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);

      // One iteration: multiply shifts right with add, divide shifts left with trial subtract.
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      div_sub   = div_shift[XLEN-1:0] - b_q;
      if (op_is_div(op_q)) begin
         hi_n = div_ge ? div_sub : div_shift[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], div_ge};
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
      end

      prod     = {hi_n, lo_n};
      prod_fix = neg_q ? -prod : prod;
      quo_fix  = neg_q ? -lo_n : lo_n;
      rem_fix  = neg_q ? -hi_n : hi_n;
      case (op_q)
         MDU_MUL:                         final_res = prod_fix[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:               final_res = quo_fix;
         default:                         final_res = rem_fix;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      neg_d    = neg_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d  = acc_op;
               b_d   = b_abs;
               hi_d  = '0;
               lo_d  = a_abs;
               cnt_d = '0;
               neg_d = op_is_rem(acc_op) ? neg_a : (neg_a ^ neg_b);
               if (div_zero) begin
                  result_d = op_is_rem(acc_op) ? operand_a : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = (acc_op == MDU_DIV) ? operand_a : '0;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
               result_d = final_res;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= MDU_MUL;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign mdu_result = result_q;
   assign zero       = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic
// 64-bit reference model.
module tb_muldiv_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic [2:0]      mdu_control;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] mdu_result;
   logic            zero;

   int n_cmp  = 0;
   int n_fail = 0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .mdu_control(mdu_control),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .mdu_result (mdu_result),
      .zero       (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint          sa, sb, ub, p, q, r;
      longint unsigned pu;
      logic [31:0]     res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      res = '0;
      case (op)
         3'd0: begin p = sa * sb; res = p[31:0]; end
         3'd1: begin p = sa * sb; res = p[63:32]; end
         3'd2: begin p = sa * ub; res = p[63:32]; end
         3'd3: begin pu = {32'h0, a} * {32'h0, b}; res = pu[63:32]; end
         3'd4: begin
            if (b == 0) res = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
            else begin q = sa / sb; res = q[31:0]; end
         end
         3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) res = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = '0;
            else begin r = sa % sb; res = r[31:0]; end
         end
         default: res = (b == 0) ? a : a % b;
      endcase
      return res;
   endfunction

   function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   // Issue one request at a negedge, then check latency, value, hold behaviour and handshake.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [31:0] exp_res;
      int          lat, guard, exp_lat;
      exp_res = model(op, a, b);
      exp_lat = exp_latency(op, a, b);
      guard = 0;
      while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid    = 1'b1;
      operand_a   = a;
      operand_b   = b;
      mdu_control = op;
      out_ready   = (hold == 0);
      @(negedge clk);
      in_valid    = 1'b0;
      operand_a   = $urandom;
      operand_b   = $urandom;
      mdu_control = 3'($urandom_range(0, 7));
      lat = 1;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_result"}, mdu_result, exp_res);
      chk({tag, "_zero"}, 32'(zero), 32'(exp_res == 0));
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1;
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_result"}, mdu_result, exp_res);
         chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_after_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_after_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          seen;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      operand_a   = '0;
      operand_b   = '0;
      mdu_control = '0;
      out_ready   = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_result", mdu_result, 32'd0);
      chk("reset_zero", 32'(zero), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("mul_7x6", 3'd0, 32'd7, 32'd6, 0);
      run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
      run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
      run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
      run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
      run_op("divu_by0", 3'd5, 32'd5, 32'd0, 0);
      run_op("rem_by0", 3'd6, 32'd5, 32'd0, 0);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("divu_notovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("backpressure", 3'd0, 32'd1234, 32'd5678, 5);

      // Abort an operation mid-calculation with a one-cycle reset.
      in_valid    = 1'b1;
      operand_a   = 32'd5;
      operand_b   = 32'd5;
      mdu_control = 3'd0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_result", mdu_result, 32'd0);
      chk("abort_zero", 32'(zero), 32'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      run_op("mul_3x3", 3'd0, 32'd3, 32'd3, 0);

      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       ra = 32'($urandom_range(0, 20));
            1:       ra = 32'h8000_0000;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), rop, ra, rb, $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
